// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin mux feeder.
// Exports feed_state_t, SEL_A/SEL_B and the burst counter width helper.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_A,
    GRANT_B
  } feed_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic int cnt_w(input int mb);
    return $clog2(mb + 1);
  endfunction

endpackage

// File: rtl/mux_rr_feeder_if.sv
// Two valid/ready source channels plus one registered output channel.
// slave: feeder side; master: source/sink side.
interface mux_rr_feeder_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  a_valid, a_data,
    input  b_valid, b_data,
    input  out_ready,
    output a_ready, b_ready,
    output sel, out_valid, out_data
  );

  modport master (
    output a_valid, a_data,
    output b_valid, b_data,
    output out_ready,
    input  a_ready, b_ready,
    input  sel, out_valid, out_data
  );
endinterface

// File: rtl/mux_rr_pick.sv
// Combinational round-robin pick with bounded bursts.
// in: a_valid, b_valid, state, burst_cnt, last_sel; out: pick (0=A, 1=B)
module mux_rr_pick
  import mux_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = cnt_w(MAX_BURST)
) (
  input  logic          a_valid,
  input  logic          b_valid,
  input  feed_state_t   state,
  input  logic [CW-1:0] burst_cnt,
  input  logic          last_sel,
  output logic          pick
);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  logic cap;
  assign cap = (burst_cnt >= MAXC);

  always_comb begin
    pick = SEL_A;
    unique case (1'b1)
      !b_valid: pick = SEL_A;
      !a_valid && b_valid: pick = SEL_B;
      a_valid && b_valid: begin
        unique case (state)
          GRANT_A: pick = cap ? SEL_B : SEL_A;
          GRANT_B: pick = cap ? SEL_A : SEL_B;
          default: pick = !last_sel;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/mux_rr_feeder.sv
// Round-robin arbiter + output register feeding the 2:1 mux.
// Ports: clk, rst_n, bus (slave: A/B sources in, sel/out_* out).
module mux_rr_feeder
  import mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_rr_feeder_if.slave bus
);
  localparam int CW = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  feed_state_t      state;
  logic [CW-1:0]    burst_cnt;
  logic             last_sel;
  logic             valid_q;
  logic             sel_q;
  logic [WIDTH-1:0] data_q;

  logic pick;
  logic load_en;
  logic any_v;
  logic accept;
  logic same;

  mux_rr_pick #(
    .MAX_BURST(MAX_BURST),
    .CW(CW)
  ) u_pick (
    .a_valid(bus.a_valid),
    .b_valid(bus.b_valid),
    .state(state),
    .burst_cnt(burst_cnt),
    .last_sel(last_sel),
    .pick(pick)
  );

  assign load_en = !valid_q || bus.out_ready;
  assign any_v   = bus.a_valid || bus.b_valid;
  assign accept  = load_en && any_v;

  // rst_n gate: the empty register would otherwise look ready in reset
  assign bus.a_ready =
    rst_n && load_en && bus.a_valid && (pick == SEL_A);
  assign bus.b_ready =
    rst_n && load_en && bus.b_valid && (pick == SEL_B);

  assign same = (state == GRANT_A && pick == SEL_A)
             || (state == GRANT_B && pick == SEL_B);

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      sel_q     <= SEL_A;
      state     <= IDLE;
      burst_cnt <= '0;
      last_sel  <= SEL_B;
    end else if (accept) begin
      valid_q  <= 1'b1;
      data_q   <= (pick == SEL_B) ? bus.b_data : bus.a_data;
      sel_q    <= pick;
      last_sel <= pick;
      state    <= (pick == SEL_B) ? GRANT_B : GRANT_A;
      if (!same)
        burst_cnt <= CW'(1);
      else if (burst_cnt != MAXC)
        burst_cnt <= burst_cnt + 1'b1;
    end else if (load_en) begin
      valid_q   <= 1'b0;
      state     <= IDLE;
      burst_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_mux_rr_feeder.sv
// Directed bench for mux_rr_feeder.
// Drives A/B sources and sink through the interface.
module tb_mux_rr_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mux_rr_feeder_if #(.WIDTH(8)) bus();

  mux_rr_feeder #(
    .WIDTH(8),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp_v);
    end
  endtask

  task automatic beat(input string tag,
                      input logic av, input logic [7:0] ad,
                      input logic bv, input logic [7:0] bd,
                      input logic ear, input logic ebr,
                      input logic ev, input logic [7:0] ed,
                      input logic es);
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
    #1;
    chk({tag, ".a_ready"}, 32'(bus.a_ready), 32'(ear));
    chk({tag, ".b_ready"}, 32'(bus.b_ready), 32'(ebr));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, ".out_data"}, 32'(bus.out_data), 32'(ed));
    chk({tag, ".sel"}, 32'(bus.sel), 32'(es));
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] exp3 [12] = '{
    8'hA0, 8'hA1, 8'hA2, 8'hA3,
    8'hB0, 8'hB1, 8'hB2, 8'hB3,
    8'hA4, 8'hA5, 8'hA6, 8'hA7
  };

  initial begin
    int ai;
    int bi;
    logic is_a;
    bus.a_valid   = 1'b1;
    bus.a_data    = 8'h00;
    bus.b_valid   = 1'b1;
    bus.b_data    = 8'h00;
    bus.out_ready = 1'b1;
    #1;
    chk("rst.a_ready", 32'(bus.a_ready), 32'd0);
    chk("rst.b_ready", 32'(bus.b_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_data", 32'(bus.out_data), 32'd0);
    chk("rst.sel", 32'(bus.sel), 32'd0);
    rst_n = 1'b1;

    // first tie after reset goes to A; then load a B beat
    beat("t1a", 1, 8'h77, 1, 8'h88, 1, 0, 1, 8'h77, 0);
    beat("t1b", 0, 8'h00, 1, 8'h88, 0, 1, 1, 8'h88, 1);
    rst_n = 1'b0;
    #1;
    chk("t1r.out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1r.out_data", 32'(bus.out_data), 32'd0);
    chk("t1r.sel", 32'(bus.sel), 32'd0);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #1;
    chk("t1r.a_ready", 32'(bus.a_ready), 32'd0);
    chk("t1r.b_ready", 32'(bus.b_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat("t1c", 1, 8'h99, 1, 8'h88, 1, 0, 1, 8'h99, 0);

    // only A valid: no cutoff past MAX_BURST
    for (int i = 0; i < 6; i++)
      beat("t2", 1, 8'(8'h11 + i), 0, 8'h00,
           1, 0, 1, 8'(8'h11 + i), 0);

    // both valid: bursts of 4 alternate
    rst_pulse();
    ai = 0;
    bi = 0;
    for (int i = 0; i < 12; i++) begin
      is_a = (exp3[i][7:4] == 4'hA);
      beat("t3", 1, 8'(8'hA0 + ai), 1, 8'(8'hB0 + bi),
           is_a, !is_a, 1, exp3[i], !is_a);
      if (is_a) ai++;
      else bi++;
    end

    // stall holds A7; drain then hands over to B
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      beat("t4s", 1, 8'hA8, 1, 8'hB4, 0, 0, 1, 8'hA7, 0);
    bus.out_ready = 1'b1;
    beat("t4d", 1, 8'hA8, 1, 8'hB4, 0, 1, 1, 8'hB4, 1);

    // A gap hands grant to B; B keeps it for 4 beats
    rst_pulse();
    beat("t5a", 1, 8'h21, 0, 8'h00, 1, 0, 1, 8'h21, 0);
    beat("t5a", 1, 8'h22, 0, 8'h00, 1, 0, 1, 8'h22, 0);
    beat("t5b", 0, 8'h00, 1, 8'h31, 0, 1, 1, 8'h31, 1);
    beat("t5b", 1, 8'h23, 1, 8'h32, 0, 1, 1, 8'h32, 1);
    beat("t5b", 1, 8'h23, 1, 8'h33, 0, 1, 1, 8'h33, 1);
    beat("t5b", 1, 8'h23, 1, 8'h34, 0, 1, 1, 8'h34, 1);
    beat("t5c", 1, 8'h23, 1, 8'h35, 1, 0, 1, 8'h23, 0);

    // sources stop: idle keeps sel/data; next B beat
    beat("t6a", 0, 8'h00, 1, 8'h35, 0, 1, 1, 8'h35, 1);
    beat("t6i", 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h35, 1);
    beat("t6b", 0, 8'h00, 1, 8'h5C, 0, 1, 1, 8'h5C, 1);
    beat("t6i", 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h5C, 1);
    beat("t6t", 1, 8'h44, 1, 8'h55, 1, 0, 1, 8'h44, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
